// File: rtl/mem_responder.sv
// Memory-side responder for the VeriRISC controller.
// Single-cycle writes, fixed-latency reads, busy indication and a sticky protocol-error flag.
module mem_responder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_out_d;
  logic                data_valid_d;
  logic                busy_d;
  logic                err_d;
  logic                we_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Storage array: not reset, so contents survive rst_.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[addr] <= data_in;
    end
  end

  // State, latency counter, captured address and registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      addr_q     <= addr_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    addr_d       = addr_q;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
    busy_d       = 1'b0;
    err_d        = err;
    we_c         = 1'b0;

    case (state)
      IDLE: begin
        if (mem_rd) begin
          // Read wins a simultaneous write; the write is dropped and flagged.
          state_d = RD_WAIT;
          addr_d  = addr;
          cnt_d   = CNT_W'(RD_LAT - 1);
          busy_d  = 1'b1;
          if (mem_wr) begin
            err_d = 1'b1;
          end
        end else if (mem_wr) begin
          we_c = 1'b1;
        end
      end

      RD_WAIT: begin
        busy_d = 1'b1;
        if (mem_wr) begin
          err_d = 1'b1;
        end
        if (cnt == '0) begin
          state_d      = RD_HOLD;
          data_out_d   = mem[addr_q];
          data_valid_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      RD_HOLD: begin
        // A held mem_rd parks here; a new read needs mem_rd low first.
        if (mem_rd) begin
          if (mem_wr) begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          we_c    = mem_wr;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (RD_LAT=2, 32 x 8 storage).
module tb_mem_responder;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;

  logic              clk;
  logic              rst_;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .addr       (addr),
    .data_in    (data_in),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addr    = a;
    data_in = d;
    mem_wr  = 1'b1;
    step();
    mem_wr  = 1'b0;
  endtask

  // Single-cycle read request; returns captured data and whether a pulse arrived.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output logic got);
    got    = 1'b0;
    d      = '0;
    addr   = a;
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (data_valid) begin
        got = 1'b1;
        d   = data_out;
      end
    end
    step();
  endtask

  task automatic apply_reset();
    #2;
    rst_ = 1'b0;
    #7;
    rst_ = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ = 1'b0; addr = '0; data_in = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    #12;
    checks++;
    if ({data_out, data_valid, busy, err} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got do=%h dv=%b busy=%b err=%b, want 00 0 0 0",
               data_out, data_valid, busy, err);
    end
    #3;
    rst_ = 1'b1;
    step();
  endtask

  task automatic test_basic_read();
    do_write(5'd3, 8'h5A);
    addr = 5'd3; mem_rd = 1'b1;
    step();  // E0
    mem_rd = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_e0: got busy=%b dv=%b, want 1 0", busy, data_valid);
    end
    step();  // E0+1
    checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_e1: got busy=%b dv=%b, want 1 0", busy, data_valid);
    end
    step();  // E0+2
    checks++;
    if ({busy, data_valid, data_out, err} !== {2'b01, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL basic_e2: got busy=%b dv=%b do=%h err=%b, want 0 1 5a 0",
               busy, data_valid, data_out, err);
    end
    step();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h5A) begin
      errors++;
      $display("FAIL basic_pulse_width: got dv=%b do=%h, want 0 5a", data_valid, data_out);
    end
  endtask

  task automatic test_held_read();
    int pulses = 0;
    do_write(5'd31, 8'hC3);
    addr = 5'd31; mem_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (data_valid) pulses++;
    end
    mem_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (data_valid) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL held_pulse_count: got %0d, want 1", pulses);
    end
    checks++;
    if (data_out !== 8'hC3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_data: got do=%h busy=%b, want c3 0", data_out, busy);
    end
  endtask

  task automatic test_rd_wr_collision();
    logic [DATA_W-1:0] d;
    logic got;
    do_write(5'd7, 8'h11);
    addr = 5'd7; data_in = 8'hFF; mem_rd = 1'b1; mem_wr = 1'b1;
    step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL collision_err: got %b, want 1", err);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (data_valid) begin
        got = 1'b1;
        d = data_out;
      end
    end
    checks++;
    if (!got || d !== 8'h11) begin
      errors++;
      $display("FAIL collision_read: got valid=%b do=%h, want 1 11", got, d);
    end
    step();
    do_read(5'd7, d, got);
    checks++;
    if (!got || d !== 8'h11) begin
      errors++;
      $display("FAIL collision_readback: got valid=%b do=%h, want 1 11", got, d);
    end
  endtask

  task automatic test_write_during_read();
    logic [DATA_W-1:0] d;
    logic got;
    apply_reset();
    do_write(5'd4, 8'h44);
    do_write(5'd2, 8'h22);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wdr_err_before: got %b, want 0", err);
    end
    addr = 5'd2; mem_rd = 1'b1;
    step();
    mem_rd = 1'b0; addr = 5'd4; data_in = 8'hEE; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL wdr_err_after: got %b, want 1", err);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (data_valid) begin
        got = 1'b1;
        d = data_out;
      end else begin
        step();
      end
    end
    checks++;
    if (!got || d !== 8'h22) begin
      errors++;
      $display("FAIL wdr_read: got valid=%b do=%h, want 1 22", got, d);
    end
    step();
    do_read(5'd4, d, got);
    checks++;
    if (!got || d !== 8'h44) begin
      errors++;
      $display("FAIL wdr_readback: got valid=%b do=%h, want 1 44", got, d);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [DATA_W-1:0] d;
    logic got;
    int pulses = 0;
    do_write(5'd9, 8'h77);
    addr = 5'd9; mem_rd = 1'b1;
    step();  // E0
    mem_rd = 1'b0;
    step();  // one cycle into RD_WAIT, completion due next edge
    rst_ = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, busy, err} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL midreset_outputs: got do=%h dv=%b busy=%b err=%b, want 00 0 0 0",
               data_out, data_valid, busy, err);
    end
    step();
    rst_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (data_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL midreset_no_pulse: got pulses=%0d do=%h, want 0 00", pulses, data_out);
    end
    do_read(5'd9, d, got);
    checks++;
    if (!got || d !== 8'h77) begin
      errors++;
      $display("FAIL midreset_retained: got valid=%b do=%h, want 1 77", got, d);
    end
  endtask

  task automatic test_read_after_write();
    addr = 5'd0; data_in = 8'h9C; mem_wr = 1'b1;
    step();  // E: write commits
    mem_wr = 1'b0; mem_rd = 1'b1;
    step();  // E+1: request sampled
    mem_rd = 1'b0;
    step();  // E+2
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_early: got dv=%b, want 0", data_valid);
    end
    step();  // E+1+RD_LAT
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h9C) begin
      errors++;
      $display("FAIL raw_data: got dv=%b do=%h, want 1 9c", data_valid, data_out);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_held_read();
    test_rd_wr_collision();
    test_write_during_read();
    test_reset_mid_read();
    test_read_after_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
